ov5647_sccb_target: RTL and testbench
=====================================

# ov5647_sccb_target

- Synthesizable SCCB/I2C target (responder) that emulates the OV5647 register port.
- Lets the camera-init controller and its SCCB initiator run against the FPGA itself: loopback bring-up, plus a sensor-less register model in simulation.
- Decodes the 16-bit-address / 8-bit-data write protocol and the current-address read protocol.
- Presents each decoded access as a strobe on a parallel register bus.

## Interface
Parameters:
- SID, 8'h6C: 8-bit device write address. SID|1 selects a read; any other ID is not acknowledged.

Ports:
- clk  in  1  system clock, 50 MHz.
- rst  in  1  reset; one clock, synchronous, active-high.
- sioc  in  1  SCCB clock from the initiator; asynchronous to clk.
- siod_i  in  1  SCCB data line as seen at the pad.
- siod_oe  out  1  1 = pull siod low. The pad is open-drain and never driven high.
- wr_valid  out  1  one-cycle write strobe.
- wr_addr  out  16  register address for wr_valid.
- wr_data  out  8  register data for wr_valid.
- rd_req  out  1  one-cycle read request.
- rd_addr  out  16  register address for rd_req.
- rd_data  in  8  read data; must be valid 2 clk after rd_req and held until the byte is shifted out.
- busy  out  1  high from START until STOP or abort.

## Operation
Input conditioning:
- sioc and siod_i each pass through a 2-flop synchronizer, then a previous-value register, giving edge detects.
- START: synced siod falls while synced sioc is high.
- STOP: synced siod rises while synced sioc is high.
- Data bits are sampled on a sioc rising edge, MSB first.

State machine:
- States: IDLE, DEV, DEV_ACK, AH, AH_ACK, AL, AL_ACK, WDATA, WDATA_ACK, RDATA, RD_ACK, IGNORE.
- START in any state, including repeated START, goes to DEV with the bit counter cleared.
- STOP in any state goes to IDLE, releases siod_oe and clears busy.
- DEV, after 8 bits:
  - ID == SID: go to DEV_ACK, then AH.
  - ID == SID|1: go to DEV_ACK, then RDATA.
  - Otherwise: go to IGNORE with no ACK. IGNORE waits for START or STOP.
- Address phase: AH loads addr[15:8], AL loads addr[7:0]. Each byte is ACKed.
- WDATA byte: ACK, pulse wr_valid with the current addr, then increment addr by 1 (16-bit wrap, 0xFFFF→0x0000). Return to WDATA for burst writes.
- Stored addr persists across transactions and is the address used by reads.
- Entering RDATA:
  - pulse rd_req with rd_addr = addr;
  - load rd_data into the shift register 2 clk later;
  - increment addr.
- RDATA drives each bit as siod_oe = ~bit.
- RD_ACK:
  - master ACK (sampled 0): start the next read byte (new rd_req).
  - master NACK: release the line and go to IGNORE.
- A byte cut short by START or STOP produces no wr_valid.

## Timing
- Reset values: siod_oe 0, wr_valid 0, wr_addr 0, wr_data 0, rd_req 0, rd_addr 0, busy 0, stored addr 0, state IDLE.
- Reset during a transfer: state returns to IDLE and siod_oe is released on the next clk. Bus traffic is ignored until the next START.
- ACK drive: siod_oe is set within 3 clk of the sioc falling edge after bit 8, and released within 3 clk of the following falling edge.
- Read data bits change within 3 clk of each sioc falling edge.
- wr_valid asserts 1–3 clk after the sioc falling edge that ends WDATA_ACK; one pulse per byte.
- Supported sioc: ≤ 400 kHz. At 50 MHz each half period is ≥ 62 clk, which covers the 2-clk rd_data latency.
- A sioc and siod change in the same clk is resolved by order of precedence: START/STOP detection wins over bit sampling.

## Structure
- Shared package `sccb_pkg` holds:
  - the state enum;
  - the default SID 8'h6C;
  - constants for the read/write bit position and the ACK level.
- One natural sub-module, `sccb_line_sync`: 2-flop synchronizer plus edge detector for sioc and siod. It outputs rise/fall/START/STOP pulses.

## Test plan
- Write 6C,01,00,01 then STOP:
  - four ACKs;
  - exactly one wr_valid with wr_addr 0x0100, wr_data 0x01;
  - busy falls after STOP.
- Wrong ID 78,30,34,1A: no ACK on any byte, no wr_valid, state IGNORE until STOP.
- Burst 6C,30,34,1A,1B: wr_valid for 0x3034=0x1A and then 0x3035=0x1B. Stored addr ends at 0x3036.
- Write 6C,30,0A, repeated START, then 6D with rd_data model returning 0x56:
  - rd_req with rd_addr 0x300A;
  - siod carries 0x56 MSB first;
  - master NACK releases the line.
- STOP after 4 bits of WDATA: no wr_valid, state IDLE, siod_oe 0.
- rst asserted mid-ACK: siod_oe 0 next clk, all outputs at reset values, and a following full write transaction succeeds.

Source files
------------

// File: rtl/sccb_pkg.sv
// Shared types and constants for the OV5647 SCCB register-port emulator.
package sccb_pkg;

  typedef enum logic [3:0] {
    IDLE,
    DEV,
    DEV_ACK,
    AH,
    AH_ACK,
    AL,
    AL_ACK,
    WDATA,
    WDATA_ACK,
    RDATA,
    RD_ACK,
    IGNORE
  } sccb_state_e;

  // OV5647 write address; the read address has the R/W bit set.
  localparam logic [7:0] SCCB_DEFAULT_SID = 8'h6C;
  localparam int unsigned RW_BIT_POS = 0;

  // Level the receiver puts on siod to acknowledge a byte.
  localparam logic ACK_LEVEL = 1'b0;

  // Clocks between rd_req and the cycle rd_data is captured, plus one.
  localparam logic [1:0] RD_LOAD_DELAY = 2'd3;

  function automatic logic [7:0] read_id(input logic [7:0] sid);
    return sid | (8'h01 << RW_BIT_POS);
  endfunction

endpackage

// File: rtl/ov5647_sccb_target_if.sv
// Parallel register bus between the SCCB target and the register model.
interface ov5647_sccb_target_if;

  logic        wr_valid;
  logic [15:0] wr_addr;
  logic [7:0]  wr_data;
  logic        rd_req;
  logic [15:0] rd_addr;
  logic [7:0]  rd_data;

  modport master (
    output wr_valid, wr_addr, wr_data, rd_req, rd_addr,
    input  rd_data
  );

  modport slave (
    input  wr_valid, wr_addr, wr_data, rd_req, rd_addr,
    output rd_data
  );

endinterface

// File: rtl/sccb_line_sync.sv
// Brings sioc/siod into the clk domain and flags edges, START and STOP.
module sccb_line_sync (
  input  logic clk,
  input  logic rst,
  input  logic sioc,
  input  logic siod,
  output logic siod_lvl,
  output logic sioc_rise,
  output logic sioc_fall,
  output logic start_det,
  output logic stop_det
);

  // Bit 0 is the metastability stage, bit 1 the synced level, bit 2 the previous synced level.
  logic [2:0] sioc_q, sioc_d;
  logic [2:0] siod_q, siod_d;

  // Shift each line one stage deeper per clock.
  always_comb begin
    sioc_d = {sioc_q[1:0], sioc};
    siod_d = {siod_q[1:0], siod};
  end

  // Reset to the idle-bus level so no edge is seen while coming out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sioc_q <= 3'b111;
      siod_q <= 3'b111;
    end else begin
      sioc_q <= sioc_d;
      siod_q <= siod_d;
    end
  end

  assign siod_lvl  = siod_q[1];
  assign sioc_rise = sioc_q[1] & ~sioc_q[2];
  assign sioc_fall = ~sioc_q[1] & sioc_q[2];
  assign start_det = sioc_q[1] & siod_q[2] & ~siod_q[1];
  assign stop_det  = sioc_q[1] & ~siod_q[2] & siod_q[1];

endmodule

// File: rtl/ov5647_sccb_target.sv
// SCCB target emulating the OV5647 register port on a parallel register bus.
module ov5647_sccb_target
  import sccb_pkg::*;
#(
  parameter logic [7:0] SID = SCCB_DEFAULT_SID
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        sioc,
  input  logic                        siod_i,
  output logic                        siod_oe,
  output logic                        busy,
  ov5647_sccb_target_if.master        bus
);

  logic siod_lvl, sioc_rise, sioc_fall, start_det, stop_det;

  sccb_line_sync u_sync (
    .clk       (clk),
    .rst       (rst),
    .sioc      (sioc),
    .siod      (siod_i),
    .siod_lvl  (siod_lvl),
    .sioc_rise (sioc_rise),
    .sioc_fall (sioc_fall),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  sccb_state_e state_q, state_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic [15:0] addr_q, addr_d;
  logic        rw_q, rw_d;
  logic [1:0]  load_cnt_q, load_cnt_d;
  logic        siod_oe_q, siod_oe_d;
  logic        busy_q, busy_d;
  logic        wr_valid_q, wr_valid_d;
  logic [15:0] wr_addr_q, wr_addr_d;
  logic [7:0]  wr_data_q, wr_data_d;
  logic        rd_req_q, rd_req_d;
  logic [15:0] rd_addr_q, rd_addr_d;
  logic        start_read;

  // Protocol decoder: bus conditions first, then per-state bit handling, then read launch.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    addr_d     = addr_q;
    rw_d       = rw_q;
    load_cnt_d = load_cnt_q;
    siod_oe_d  = siod_oe_q;
    busy_d     = busy_q;
    wr_valid_d = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    rd_req_d   = 1'b0;
    rd_addr_d  = rd_addr_q;
    start_read = 1'b0;

    if (load_cnt_q != 2'd0) begin
      load_cnt_d = load_cnt_q - 2'd1;
      if (load_cnt_q == 2'd1) begin
        shift_d   = bus.rd_data;
        siod_oe_d = ~bus.rd_data[7];
      end
    end

    if (stop_det) begin
      state_d    = IDLE;
      siod_oe_d  = 1'b0;
      busy_d     = 1'b0;
      load_cnt_d = 2'd0;
    end else if (start_det) begin
      state_d    = DEV;
      bit_cnt_d  = 4'd0;
      siod_oe_d  = 1'b0;
      busy_d     = 1'b1;
      load_cnt_d = 2'd0;
    end else begin
      case (state_q)
        DEV, AH, AL, WDATA: begin
          if (sioc_rise && bit_cnt_q != 4'd8) begin
            shift_d   = {shift_q[6:0], siod_lvl};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (sioc_fall && bit_cnt_q == 4'd8) begin
            bit_cnt_d = 4'd0;
            siod_oe_d = ~ACK_LEVEL;
            case (state_q)
              DEV: begin
                if (shift_q == SID) begin
                  rw_d    = 1'b0;
                  state_d = DEV_ACK;
                end else if (shift_q == read_id(SID)) begin
                  rw_d    = 1'b1;
                  state_d = DEV_ACK;
                end else begin
                  siod_oe_d = 1'b0;
                  state_d   = IGNORE;
                end
              end
              AH: begin
                addr_d[15:8] = shift_q;
                state_d      = AH_ACK;
              end
              AL: begin
                addr_d[7:0] = shift_q;
                state_d     = AL_ACK;
              end
              default: state_d = WDATA_ACK;
            endcase
          end
        end
        DEV_ACK, AH_ACK, AL_ACK, WDATA_ACK: begin
          if (sioc_fall) begin
            siod_oe_d = 1'b0;
            case (state_q)
              DEV_ACK: begin
                if (rw_q) start_read = 1'b1;
                else      state_d    = AH;
              end
              AH_ACK: state_d = AL;
              AL_ACK: state_d = WDATA;
              default: begin
                wr_valid_d = 1'b1;
                wr_addr_d  = addr_q;
                wr_data_d  = shift_q;
                addr_d     = addr_q + 16'd1;
                state_d    = WDATA;
              end
            endcase
          end
        end
        RDATA: begin
          if (sioc_fall && load_cnt_q == 2'd0) begin
            if (bit_cnt_q == 4'd7) begin
              bit_cnt_d = 4'd0;
              siod_oe_d = 1'b0;
              state_d   = RD_ACK;
            end else begin
              bit_cnt_d = bit_cnt_q + 4'd1;
              shift_d   = {shift_q[6:0], 1'b0};
              siod_oe_d = ~shift_q[6];
            end
          end
        end
        RD_ACK: begin
          if (sioc_rise && siod_lvl != ACK_LEVEL) state_d = IGNORE;
          else if (sioc_fall)                    start_read = 1'b1;
        end
        default: ;
      endcase
    end

    if (start_read) begin
      state_d    = RDATA;
      rd_req_d   = 1'b1;
      rd_addr_d  = addr_q;
      addr_d     = addr_q + 16'd1;
      load_cnt_d = RD_LOAD_DELAY;
      bit_cnt_d  = 4'd0;
      siod_oe_d  = 1'b0;
    end
  end

  // All state and outputs are registered here; reset returns everything to idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      bit_cnt_q  <= 4'd0;
      shift_q    <= 8'd0;
      addr_q     <= 16'd0;
      rw_q       <= 1'b0;
      load_cnt_q <= 2'd0;
      siod_oe_q  <= 1'b0;
      busy_q     <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= 16'd0;
      wr_data_q  <= 8'd0;
      rd_req_q   <= 1'b0;
      rd_addr_q  <= 16'd0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      addr_q     <= addr_d;
      rw_q       <= rw_d;
      load_cnt_q <= load_cnt_d;
      siod_oe_q  <= siod_oe_d;
      busy_q     <= busy_d;
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      rd_req_q   <= rd_req_d;
      rd_addr_q  <= rd_addr_d;
    end
  end

  assign siod_oe      = siod_oe_q;
  assign busy         = busy_q;
  assign bus.wr_valid = wr_valid_q;
  assign bus.wr_addr  = wr_addr_q;
  assign bus.wr_data  = wr_data_q;
  assign bus.rd_req   = rd_req_q;
  assign bus.rd_addr  = rd_addr_q;

endmodule

// File: tb/tb_ov5647_sccb_target.sv
// Directed bench for ov5647_sccb_target: an SCCB master model drives the bus,
// the register bus is logged, and every result is compared to hand-derived values.
module tb_ov5647_sccb_target;
  import sccb_pkg::*;

  localparam int HALF = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sioc = 1'b1;
  logic siodM = 1'b1;
  logic siodOe;
  logic busy;
  logic siodLine;

  int checks = 0;
  int errors = 0;

  int wrCount = 0;
  int rdCount = 0;
  int oeCycles = 0;
  logic [15:0] wrAddrLog [8];
  logic [7:0]  wrDataLog [8];
  logic [15:0] rdAddrLog [8];

  // Open-drain wired-AND of the master and the target.
  assign siodLine = siodM & ~siodOe;

  ov5647_sccb_target_if bus ();

  ov5647_sccb_target #(.SID(8'h6C)) dut (
    .clk     (clk),
    .rst     (rst),
    .sioc    (sioc),
    .siod_i  (siodLine),
    .siod_oe (siodOe),
    .busy    (busy),
    .bus     (bus)
  );

  // 50 MHz system clock.
  always #10 clk = ~clk;

  // Log every strobe and every cycle the target pulls siod low.
  always @(negedge clk) begin
    if (bus.wr_valid) begin
      if (wrCount < 8) begin
        wrAddrLog[wrCount] = bus.wr_addr;
        wrDataLog[wrCount] = bus.wr_data;
      end
      wrCount++;
    end
    if (bus.rd_req) begin
      if (rdCount < 8) rdAddrLog[rdCount] = bus.rd_addr;
      rdCount++;
    end
    if (siodOe === 1'b1) oeCycles++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic waitClk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic sccbStart();
    waitClk(HALF / 2); siodM = 1'b1;
    waitClk(HALF / 2); sioc = 1'b1;
    waitClk(HALF / 2); siodM = 1'b0;
    waitClk(HALF / 2); sioc = 1'b0;
  endtask

  task automatic sccbStop();
    waitClk(HALF / 2); siodM = 1'b0;
    waitClk(HALF / 2); sioc = 1'b1;
    waitClk(HALF / 2); siodM = 1'b1;
    waitClk(HALF / 2);
  endtask

  task automatic sccbBit(input logic b);
    waitClk(HALF / 2); siodM = b;
    waitClk(HALF / 2); sioc = 1'b1;
    waitClk(HALF);     sioc = 1'b0;
  endtask

  task automatic sccbSample(output logic b);
    waitClk(HALF / 2); siodM = 1'b1;
    waitClk(HALF / 2); sioc = 1'b1;
    waitClk(HALF / 2); b = siodLine;
    waitClk(HALF / 2); sioc = 1'b0;
  endtask

  // One written byte plus the ACK clock; acked is 1 when the target pulled siod low.
  task automatic applyStimulus(input logic [7:0] data, output logic acked);
    logic line;
    for (int i = 7; i >= 0; i--) sccbBit(data[i]);
    sccbSample(line);
    acked = (line == 1'b0);
  endtask

  task automatic sendBytes(input logic [7:0] seq [5], input int n, output int acks);
    logic a;
    acks = 0;
    for (int i = 0; i < n; i++) begin
      applyStimulus(seq[i], a);
      if (a) acks++;
    end
  endtask

  // One read byte; nextData is presented for the following rd_req before the master ACK bit.
  task automatic readByte(input logic masterAck, input logic [7:0] nextData, output logic [7:0] data);
    logic b;
    data = 8'h00;
    for (int i = 0; i < 8; i++) begin
      sccbSample(b);
      data = {data[6:0], b};
    end
    bus.rd_data = nextData;
    sccbBit(masterAck ? 1'b0 : 1'b1);
  endtask

  initial begin
    int acks;
    int wrBase;
    int rdBase;
    int oeBase;
    logic a;
    logic [7:0] rx;

    bus.rd_data = 8'h00;
    waitClk(5);
    rst = 1'b0;
    waitClk(2);

    checkOutput("reset_siod_oe",  32'(siodOe), 32'h0);
    checkOutput("reset_busy",     32'(busy), 32'h0);
    checkOutput("reset_wr_valid", 32'(bus.wr_valid), 32'h0);
    checkOutput("reset_rd_req",   32'(bus.rd_req), 32'h0);
    checkOutput("reset_wr_addr",  32'(bus.wr_addr), 32'h0);
    checkOutput("reset_rd_addr",  32'(bus.rd_addr), 32'h0);
    checkOutput("reset_state",    32'(dut.state_q), 32'(IDLE));

    // Single write 6C,01,00,01.
    wrBase = wrCount;
    sccbStart();
    sendBytes('{8'h6C, 8'h01, 8'h00, 8'h01, 8'h00}, 4, acks);
    checkOutput("w1_acks", 32'(acks), 32'd4);
    checkOutput("w1_busy_high", 32'(busy), 32'h1);
    sccbStop();
    waitClk(8);
    checkOutput("w1_wr_count", 32'(wrCount - wrBase), 32'd1);
    checkOutput("w1_wr_addr", 32'(wrAddrLog[wrBase]), 32'h0100);
    checkOutput("w1_wr_data", 32'(wrDataLog[wrBase]), 32'h01);
    checkOutput("w1_busy_low", 32'(busy), 32'h0);

    // Wrong device ID is ignored entirely.
    wrBase = wrCount;
    oeBase = oeCycles;
    sccbStart();
    applyStimulus(8'h78, a);
    checkOutput("wid_state_after_id", 32'(dut.state_q), 32'(IGNORE));
    sendBytes('{8'h30, 8'h34, 8'h1A, 8'h00, 8'h00}, 3, acks);
    checkOutput("wid_acks", 32'(acks + (a ? 1 : 0)), 32'd0);
    checkOutput("wid_state_end", 32'(dut.state_q), 32'(IGNORE));
    sccbStop();
    waitClk(8);
    checkOutput("wid_oe_cycles", 32'(oeCycles - oeBase), 32'd0);
    checkOutput("wid_wr_count", 32'(wrCount - wrBase), 32'd0);
    checkOutput("wid_state_idle", 32'(dut.state_q), 32'(IDLE));

    // Burst write with address auto-increment.
    wrBase = wrCount;
    sccbStart();
    sendBytes('{8'h6C, 8'h30, 8'h34, 8'h1A, 8'h1B}, 5, acks);
    sccbStop();
    waitClk(8);
    checkOutput("burst_acks", 32'(acks), 32'd5);
    checkOutput("burst_wr_count", 32'(wrCount - wrBase), 32'd2);
    checkOutput("burst_addr0", 32'(wrAddrLog[wrBase]), 32'h3034);
    checkOutput("burst_data0", 32'(wrDataLog[wrBase]), 32'h1A);
    checkOutput("burst_addr1", 32'(wrAddrLog[wrBase + 1]), 32'h3035);
    checkOutput("burst_data1", 32'(wrDataLog[wrBase + 1]), 32'h1B);
    checkOutput("burst_stored_addr", 32'(dut.addr_q), 32'h3036);

    // Address set, repeated START, two-byte read ending in NACK.
    wrBase = wrCount;
    rdBase = rdCount;
    bus.rd_data = 8'h56;
    sccbStart();
    sendBytes('{8'h6C, 8'h30, 8'h0A, 8'h00, 8'h00}, 3, acks);
    checkOutput("rd_setup_acks", 32'(acks), 32'd3);
    sccbStart();
    applyStimulus(8'h6D, a);
    checkOutput("rd_id_ack", 32'(a), 32'h1);
    readByte(1'b1, 8'hA5, rx);
    checkOutput("rd_byte0", 32'(rx), 32'h56);
    checkOutput("rd_addr0", 32'(rdAddrLog[rdBase]), 32'h300A);
    readByte(1'b0, 8'h00, rx);
    checkOutput("rd_byte1", 32'(rx), 32'hA5);
    checkOutput("rd_addr1", 32'(rdAddrLog[rdBase + 1]), 32'h300B);
    checkOutput("rd_req_count", 32'(rdCount - rdBase), 32'd2);
    waitClk(8);
    checkOutput("rd_nack_oe", 32'(siodOe), 32'h0);
    checkOutput("rd_nack_state", 32'(dut.state_q), 32'(IGNORE));
    sccbStop();
    waitClk(8);
    checkOutput("rd_wr_count", 32'(wrCount - wrBase), 32'd0);
    checkOutput("rd_stored_addr", 32'(dut.addr_q), 32'h300C);

    // STOP after four data bits produces no write.
    wrBase = wrCount;
    sccbStart();
    sendBytes('{8'h6C, 8'h12, 8'h34, 8'h00, 8'h00}, 3, acks);
    for (int i = 0; i < 4; i++) sccbBit(1'b1);
    sccbStop();
    waitClk(8);
    checkOutput("cut_wr_count", 32'(wrCount - wrBase), 32'd0);
    checkOutput("cut_state", 32'(dut.state_q), 32'(IDLE));
    checkOutput("cut_oe", 32'(siodOe), 32'h0);
    checkOutput("cut_busy", 32'(busy), 32'h0);

    // Reset while the target is driving an ACK, then a clean write.
    sccbStart();
    applyStimulus(8'h6C, a);
    for (int i = 7; i >= 0; i--) sccbBit(i[0]);
    waitClk(HALF / 2);
    siodM = 1'b1;
    checkOutput("rst_ack_active", 32'(siodOe), 32'h1);
    rst = 1'b1;
    waitClk(1);
    rst = 1'b0;
    checkOutput("rst_oe", 32'(siodOe), 32'h0);
    checkOutput("rst_busy", 32'(busy), 32'h0);
    checkOutput("rst_state", 32'(dut.state_q), 32'(IDLE));
    checkOutput("rst_wr_addr", 32'(bus.wr_addr), 32'h0);
    checkOutput("rst_wr_data", 32'(bus.wr_data), 32'h0);
    checkOutput("rst_rd_addr", 32'(bus.rd_addr), 32'h0);
    checkOutput("rst_stored_addr", 32'(dut.addr_q), 32'h0);
    oeBase = oeCycles;
    waitClk(HALF / 2); sioc = 1'b1;
    waitClk(HALF);     sioc = 1'b0;
    sccbBit(1'b0);
    checkOutput("rst_bus_ignored", 32'(oeCycles - oeBase), 32'd0);
    wrBase = wrCount;
    sccbStart();
    sendBytes('{8'h6C, 8'h55, 8'hAA, 8'h77, 8'h00}, 4, acks);
    sccbStop();
    waitClk(8);
    checkOutput("post_rst_acks", 32'(acks), 32'd4);
    checkOutput("post_rst_wr_count", 32'(wrCount - wrBase), 32'd1);
    checkOutput("post_rst_wr_addr", 32'(wrAddrLog[wrBase]), 32'h55AA);
    checkOutput("post_rst_wr_data", 32'(wrDataLog[wrBase]), 32'h77);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
